// File: rtl/cell_plotter_if.sv
// Bundle between the coordinate/draw controller and the cell plotter datapath.
interface cell_plotter_if #(
  parameter int COLOUR_W = 3
);
  logic                ldX;
  logic                ldY;
  logic [7:0]          loadVal;
  logic                draw;
  logic [COLOUR_W-1:0] colour_in;
  logic [7:0]          vga_x;
  logic [6:0]          vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                plot;
  logic                busy;
  logic                done;

  // Controller side: drives load/draw requests, observes the pixel stream.
  modport master (
    output ldX, ldY, loadVal, draw, colour_in,
    input  vga_x, vga_y, vga_colour, plot, busy, done
  );

  // Plotter side: accepts requests, produces the pixel stream.
  modport slave (
    input  ldX, ldY, loadVal, draw, colour_in,
    output vga_x, vga_y, vga_colour, plot, busy, done
  );
endinterface

// File: rtl/cell_plotter.sv
// Cell plotter: latches a cell coordinate and, on each rising edge of draw,
// streams the CELL_SIZE x CELL_SIZE pixel square of that cell to the VGA
// adapter, one pixel per clock in row-major order.
module cell_plotter #(
  parameter int CELL_SIZE = 4,
  parameter int GRID_W    = 40,
  parameter int GRID_H    = 30,
  parameter int COLOUR_W  = 3
) (
  input logic           clock,
  input logic           reset,
  cell_plotter_if.slave bus
);

  localparam int         SHIFT  = $clog2(CELL_SIZE);
  localparam logic [7:0] X_MAX  = 8'(GRID_W - 1);
  localparam logic [7:0] Y_MAX  = 8'(GRID_H - 1);
  localparam logic [2:0] P_LAST = 3'(CELL_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLOT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          x_cell_q, x_cell_d;
  logic [7:0]          y_cell_q, y_cell_d;
  logic [2:0]          px_q, px_d;
  logic [2:0]          py_q, py_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                draw_q;
  logic                start_s;

  logic [7:0]          vga_x_q, vga_x_d;
  logic [6:0]          vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0] vga_colour_q, vga_colour_d;
  logic                plot_q, plot_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Holding draw high only paints once: a paint needs a fresh 0->1 edge.
  assign start_s = bus.draw & ~draw_q;

  // Coordinate loads are accepted outside PLOT only, saturated to the grid.
  always_comb begin
    x_cell_d = x_cell_q;
    y_cell_d = y_cell_q;
    if (state_q != S_PLOT) begin
      if (bus.ldX) begin
        x_cell_d = (bus.loadVal > X_MAX) ? X_MAX : bus.loadVal;
      end else begin
        x_cell_d = x_cell_q;
      end
      if (bus.ldY) begin
        y_cell_d = (bus.loadVal > Y_MAX) ? Y_MAX : bus.loadVal;
      end else begin
        y_cell_d = y_cell_q;
      end
    end else begin
      x_cell_d = x_cell_q;
      y_cell_d = y_cell_q;
    end
  end

  // Coordinate registers and draw edge detector.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_cell_q <= 8'd0;
      y_cell_q <= 8'd0;
      draw_q   <= 1'b0;
    end else begin
      x_cell_q <= x_cell_d;
      y_cell_q <= y_cell_d;
      draw_q   <= bus.draw;
    end
  end

  // FSM state register with the pixel counters and paint colour.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      px_q     <= 3'd0;
      py_q     <= 3'd0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      px_q     <= px_d;
      py_q     <= py_d;
      colour_q <= colour_d;
    end
  end

  // Next-state logic: walk px fastest, then py; a start outside IDLE is dropped.
  always_comb begin
    state_d  = state_q;
    px_d     = px_q;
    py_d     = py_q;
    colour_d = colour_q;
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          state_d  = S_PLOT;
          px_d     = 3'd0;
          py_d     = 3'd0;
          colour_d = bus.colour_in;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_PLOT: begin
        if ((px_q == P_LAST) && (py_q == P_LAST)) begin
          state_d = S_DONE;
        end else if (px_q == P_LAST) begin
          px_d = 3'd0;
          py_d = py_q + 3'd1;
        end else begin
          px_d = px_q + 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output comes straight off a flop.
  always_comb begin
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    plot_d       = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    case (state_d)
      S_PLOT: begin
        plot_d       = 1'b1;
        busy_d       = 1'b1;
        vga_x_d      = (x_cell_d << SHIFT) + {5'd0, px_d};
        vga_y_d      = 7'((y_cell_d << SHIFT) + {5'd0, py_d});
        vga_colour_d = colour_d;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      S_IDLE: begin
        done_d = 1'b0;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // Registered pixel stream towards the VGA adapter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vga_x_q      <= 8'd0;
      vga_y_q      <= 7'd0;
      vga_colour_q <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      plot_q       <= plot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;
  assign bus.plot       = plot_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_cell_plotter.sv
module tb_cell_plotter;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic clock;
  logic reset;

  cell_plotter_if #(.COLOUR_W(3)) bus ();

  cell_plotter #(
    .CELL_SIZE(4),
    .GRID_W   (40),
    .GRID_H   (30),
    .COLOUR_W (3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   plot_cnt = 0;
  logic prev_plot = 1'b0;
  pix_t sb_q[$];
  pix_t exp_e;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected pixels of one cell, row-major with x fastest.
  task automatic push_square(input int xc, input int yc, input logic [2:0] col);
    pix_t p;
    for (int py = 0; py < 4; py++) begin
      for (int px = 0; px < 4; px++) begin
        p.x = 8'(xc * 4 + px);
        p.y = 7'(yc * 4 + py);
        p.c = col;
        sb_q.push_back(p);
      end
    end
  endtask

  task automatic wait_done(input string tag);
    int start_cnt;
    bit seen;
    start_cnt = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clock);
      if (done_cnt != start_cnt) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
    check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
  endtask

  // Scoreboard monitor sampling on the falling edge.
  always @(negedge clock) begin
    if (bus.plot === 1'b1) begin
      check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        exp_e = sb_q.pop_front();
        check("vga_x", 32'(bus.vga_x), 32'(exp_e.x));
        check("vga_y", 32'(bus.vga_y), 32'(exp_e.y));
        check("vga_colour", 32'(bus.vga_colour), 32'(exp_e.c));
        check("busy_in_plot", 32'(bus.busy), 32'd1);
      end
      plot_cnt++;
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      check("done_after_last_plot", 32'(prev_plot), 32'd1);
      check("done_no_busy", 32'(bus.busy), 32'd0);
    end
    prev_plot = bus.plot;
  end

  initial begin
    int d0;
    int base;
    bit hit;
    reset = 1'b1;
    bus.ldX = 1'b0;
    bus.ldY = 1'b0;
    bus.loadVal = 8'd0;
    bus.draw = 1'b0;
    bus.colour_in = 3'd0;

    // 1: reset state, then paint cell (0,0)
    @(negedge clock);
    check("rst_plot", 32'(bus.plot), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_vga_x", 32'(bus.vga_x), 32'd0);
    check("rst_vga_y", 32'(bus.vga_y), 32'd0);
    check("rst_colour", 32'(bus.vga_colour), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    bus.colour_in = 3'b111;
    push_square(0, 0, 3'b111);
    bus.draw = 1'b1;
    @(negedge clock);
    check("t1_first_plot", 32'(bus.plot), 32'd1);
    check("t1_first_x", 32'(bus.vga_x), 32'd0);
    check("t1_first_y", 32'(bus.vga_y), 32'd0);
    bus.draw = 1'b0;
    wait_done("t1_done");

    // 2: cell (5,3) colour 010
    @(negedge clock);
    bus.ldX = 1'b1;
    bus.loadVal = 8'd5;
    @(negedge clock);
    bus.ldX = 1'b0;
    bus.ldY = 1'b1;
    bus.loadVal = 8'd3;
    @(negedge clock);
    bus.ldY = 1'b0;
    bus.colour_in = 3'b010;
    push_square(5, 3, 3'b010);
    bus.draw = 1'b1;
    @(negedge clock);
    check("t2_latency_plot", 32'(bus.plot), 32'd1);
    check("t2_latency_x", 32'(bus.vga_x), 32'd20);
    bus.draw = 1'b0;
    wait_done("t2_done");

    // 3: saturated column
    @(negedge clock);
    bus.ldX = 1'b1;
    bus.loadVal = 8'd200;
    @(negedge clock);
    bus.ldX = 1'b0;
    bus.colour_in = 3'b011;
    push_square(39, 3, 3'b011);
    bus.draw = 1'b1;
    @(negedge clock);
    bus.draw = 1'b0;
    wait_done("t3_done");

    // 4: draw held high paints once, re-arm after one low cycle
    @(negedge clock);
    bus.colour_in = 3'b100;
    push_square(39, 3, 3'b100);
    d0 = done_cnt;
    bus.draw = 1'b1;
    repeat (40) @(negedge clock);
    check("t4_one_done", 32'(done_cnt - d0), 32'd1);
    check("t4_sb_empty", 32'(sb_q.size()), 32'd0);
    bus.draw = 1'b0;
    @(negedge clock);
    push_square(39, 3, 3'b100);
    bus.draw = 1'b1;
    wait_done("t4_second_done");
    @(negedge clock);
    bus.draw = 1'b0;

    // 5: loads and colour changes during PLOT are ignored
    @(negedge clock);
    bus.colour_in = 3'b101;
    push_square(39, 3, 3'b101);
    bus.draw = 1'b1;
    @(negedge clock);
    bus.draw = 1'b0;
    repeat (3) @(negedge clock);
    bus.ldX = 1'b1;
    bus.loadVal = 8'd7;
    bus.colour_in = 3'b001;
    @(negedge clock);
    bus.ldX = 1'b0;
    wait_done("t5_done");
    @(negedge clock);
    bus.colour_in = 3'b100;
    push_square(39, 3, 3'b100);
    bus.draw = 1'b1;
    @(negedge clock);
    bus.draw = 1'b0;
    wait_done("t5_x_kept_done");

    // 6: reset during pixel 9 abandons the paint
    @(negedge clock);
    bus.colour_in = 3'b110;
    push_square(39, 3, 3'b110);
    base = plot_cnt;
    bus.draw = 1'b1;
    @(negedge clock);
    bus.draw = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(posedge clock);
      if (plot_cnt - base >= 9) hit = 1'b1;
    end
    check("t6_reach_px9", 32'(hit), 32'd1);
    d0 = done_cnt;
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_plot", 32'(bus.plot), 32'd0);
    check("t6_async_busy", 32'(bus.busy), 32'd0);
    check("t6_async_x", 32'(bus.vga_x), 32'd0);
    check("t6_async_y", 32'(bus.vga_y), 32'd0);
    sb_q.delete();
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);
    check("t6_idle_plot", 32'(bus.plot), 32'd0);
    bus.colour_in = 3'b001;
    push_square(0, 0, 3'b001);
    bus.draw = 1'b1;
    @(negedge clock);
    check("t6_restart_plot", 32'(bus.plot), 32'd1);
    check("t6_restart_x", 32'(bus.vga_x), 32'd0);
    check("t6_restart_y", 32'(bus.vga_y), 32'd0);
    bus.draw = 1'b0;
    wait_done("t6_done");

    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
